bullet_ctrl: RTL and testbench
==============================

BULLET_CTRL -- requirements
Module: bullet_ctrl

Interface
REQ-001 SHALL have parameter NSLOT, default 4, meaning number of bullet slots (2..8).
REQ-002 SHALL have parameter SPEED, default 4, meaning pixels moved per frame.
REQ-003 SHALL have parameter SCR_H, default 480, meaning screen height in pixels.
REQ-004 SHALL have port clk, input, 1, meaning single system clock; all state rising-edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port frame_tick, input, 1, meaning one-cycle pulse at vblank start.
REQ-007 SHALL have port fire_p, input, 1, meaning player fire pulse.
REQ-008 SHALL have ports p_x and p_y, input, 10 each, meaning player bullet spawn coordinates.
REQ-009 SHALL have port fire_e, input, 1, meaning enemy fire pulse.
REQ-010 SHALL have ports e_x and e_y, input, 10 each, meaning enemy bullet spawn coordinates.
REQ-011 SHALL have ports pix_x and pix_y, input, 10 each, meaning current raster pixel.
REQ-012 SHALL have ports rom_x and rom_y, output, 3 each, meaning offset into 6x6 bullet sprite ROM.
REQ-013 SHALL have port rom_en, output, 1, meaning sprite ROM enable (a bullet covers the pixel).
REQ-014 SHALL have port busy, output, 1, meaning FSM not in IDLE.
REQ-015 SHALL have port active, output, NSLOT, meaning per-slot valid bits.

Function
REQ-016 SHALL hold per slot: valid, dir (0 = player/up, 1 = enemy/down), x[9:0], y[9:0].
REQ-017 SHALL latch fire_p/fire_e into pend_p/pend_e; a repeat pulse while pending merges; a pulse on the cycle its pending bit clears leaves it set.
REQ-018 SHALL use FSM states IDLE, UPDATE, SPAWN; IDLE->UPDATE on frame_tick; frame_tick outside IDLE is ignored.
REQ-019 SHALL in UPDATE visit one slot per cycle, index 0..NSLOT-1, then go to SPAWN; UPDATE takes exactly NSLOT cycles.
REQ-020 SHALL move a valid up-slot as y-SPEED, clearing valid instead when y < SPEED (no wrap).
REQ-021 SHALL move a valid down-slot as y+SPEED, clearing valid instead when y+SPEED > SCR_H-6.
REQ-022 SHALL in SPAWN (one cycle) grant each pending request to the lowest-index free slot, loading x/y/dir from the inputs sampled that cycle.
REQ-023 SHALL, with both pending and at least two free slots, grant both to different slots.
REQ-024 SHALL, with both pending and one free slot, grant the owner of prio (reset 0 = player), keep the loser pending, and toggle prio.
REQ-025 SHALL, with no free slot, keep requests pending; SPAWN then returns to IDLE.
REQ-026 SHALL register the pixel lookup with 1-cycle latency: rom_en=1 when a valid slot has 0<=pix_x-x<=5 and 0<=pix_y-y<=5; rom_x/rom_y = those differences.
REQ-027 SHALL, when several slots cover a pixel, use the lowest index; when rom_en=0, drive rom_x=rom_y=0.
REQ-028 SHALL drive busy=1 in UPDATE and SPAWN only.

Reset
REQ-029 SHALL on rst_n low asynchronously clear: all slot state, pend_p, pend_e, prio, rom_en, rom_x, rom_y, active; FSM to IDLE; busy=0.
REQ-030 SHALL, when reset asserts mid-UPDATE or mid-SPAWN, discard the partial frame; the first frame_tick after release starts a clean UPDATE.

Configuration
REQ-031 SHALL, with macro BULLET_HIT_EN defined, add inputs hit_vld (1) and hit_idx (3), clearing that slot's valid on the next edge, taking precedence over a same-cycle UPDATE move or SPAWN load of that slot; hit_idx >= NSLOT is ignored.
REQ-032 SHALL, without BULLET_HIT_EN, omit those ports; slots free only by leaving the screen.

Verification
REQ-033 SHALL cover: fire_p at p=(100,200), frame_tick -> after NSLOT+1 cycles active=0001, slot0 y=200; next tick y=196.
REQ-034 SHALL cover: up-bullet at y=3, frame_tick -> slot freed, active bit 0, no wrap to 1023.
REQ-035 SHALL cover: 3 slots full, fire_p and fire_e same cycle, frame_tick -> player gets slot 3, enemy stays pending; after freeing one slot and next tick enemy granted; prio=1 before that SPAWN.
REQ-036 SHALL cover: slot0 at (100,200), pix=(103,205) -> next cycle rom_en=1, rom_x=3, rom_y=5; pix=(106,205) -> rom_en=0.
REQ-037 SHALL cover: rst_n low during UPDATE cycle 2 -> all outputs 0 immediately, FSM IDLE, pending fires lost.
REQ-038 SHALL cover (BULLET_HIT_EN): hit_vld with hit_idx=1 on slot 1's UPDATE cycle -> slot 1 invalid next cycle, not moved.

Source files
------------

// File: rtl/bullet_ctrl.sv
// bullet_ctrl: NSLOT bullet slots moved once per frame, spawned from pending fire
// requests, with a registered sprite-ROM pixel lookup. Define BULLET_HIT_EN for hit_vld/hit_idx.
module bullet_ctrl #(
  parameter int NSLOT = 4,
  parameter int SPEED = 4,
  parameter int SCR_H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             fire_p,
  input  logic [9:0]       p_x,
  input  logic [9:0]       p_y,
  input  logic             fire_e,
  input  logic [9:0]       e_x,
  input  logic [9:0]       e_y,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
`ifdef BULLET_HIT_EN
  input  logic             hit_vld,
  input  logic [2:0]       hit_idx,
`endif
  output logic [2:0]       rom_x,
  output logic [2:0]       rom_y,
  output logic             rom_en,
  output logic             busy,
  output logic [NSLOT-1:0] active
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    SPAWN  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [2:0]             cnt_q;
  logic                   busy_q;

  logic [NSLOT-1:0]       valid_q, valid_d;
  logic [NSLOT-1:0]       dir_q, dir_d;
  logic [NSLOT-1:0][9:0]  x_q, x_d;
  logic [NSLOT-1:0][9:0]  y_q, y_d;
  logic                   pend_p_q, pend_p_d;
  logic                   pend_e_q, pend_e_d;
  logic                   prio_q, prio_d;

  logic                   rom_en_q, rom_en_d;
  logic [2:0]             rom_x_q, rom_x_d;
  logic [2:0]             rom_y_q, rom_y_d;

  logic                   free1_vld_s, free2_vld_s;
  logic [2:0]             free1_s, free2_s;
  logic                   grant_p_s, grant_e_s, prio_flip_s;
  logic [2:0]             slot_p_s, slot_e_s;

  // Lowest and second-lowest free slot indices.
  always_comb begin
    free1_vld_s = 1'b0;
    free2_vld_s = 1'b0;
    free1_s     = 3'd0;
    free2_s     = 3'd0;
    for (int i = 0; i < NSLOT; i++) begin
      if (valid_q[i]) begin
      end else if (!free1_vld_s) begin
        free1_vld_s = 1'b1;
        free1_s     = 3'(i);
      end else if (!free2_vld_s) begin
        free2_vld_s = 1'b1;
        free2_s     = 3'(i);
      end else begin
      end
    end
  end

  // Spawn arbitration between pending player and enemy requests.
  always_comb begin
    grant_p_s   = 1'b0;
    grant_e_s   = 1'b0;
    prio_flip_s = 1'b0;
    slot_p_s    = free1_s;
    slot_e_s    = free1_s;
    if (state_q != SPAWN) begin
    end else if (pend_p_q && pend_e_q) begin
      if (free2_vld_s) begin
        grant_p_s = 1'b1;
        grant_e_s = 1'b1;
        slot_e_s  = free2_s;
      end else if (free1_vld_s) begin
        // One slot for two requesters: the prio owner wins, then ownership flips.
        grant_p_s   = ~prio_q;
        grant_e_s   = prio_q;
        prio_flip_s = 1'b1;
      end else begin
      end
    end else begin
      grant_p_s = pend_p_q & free1_vld_s;
      grant_e_s = pend_e_q & free1_vld_s;
    end
  end

  // Slot next-state: per-frame motion, spawn loads, optional hit kill.
  always_comb begin
    valid_d = valid_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    for (int i = 0; i < NSLOT; i++) begin
      if (state_q == UPDATE && cnt_q == 3'(i) && valid_q[i]) begin
        if (!dir_q[i]) begin
          if (y_q[i] < 10'(SPEED)) valid_d[i] = 1'b0;
          else                     y_d[i] = y_q[i] - 10'(SPEED);
        end else begin
          if (({1'b0, y_q[i]} + 11'(SPEED)) > 11'(SCR_H - 6)) valid_d[i] = 1'b0;
          else                                                y_d[i] = y_q[i] + 10'(SPEED);
        end
      end else if (grant_p_s && slot_p_s == 3'(i)) begin
        valid_d[i] = 1'b1;
        dir_d[i]   = 1'b0;
        x_d[i]     = p_x;
        y_d[i]     = p_y;
      end else if (grant_e_s && slot_e_s == 3'(i)) begin
        valid_d[i] = 1'b1;
        dir_d[i]   = 1'b1;
        x_d[i]     = e_x;
        y_d[i]     = e_y;
      end else begin
      end
`ifdef BULLET_HIT_EN
      if (hit_vld && hit_idx == 3'(i)) valid_d[i] = 1'b0;
      else begin
      end
`endif
    end
    pend_p_d = fire_p | (pend_p_q & ~grant_p_s);
    pend_e_d = fire_e | (pend_e_q & ~grant_e_s);
    prio_d   = prio_q ^ prio_flip_s;
  end

  // Pixel coverage; descending scan so the lowest covering index wins.
  always_comb begin
    rom_en_d = 1'b0;
    rom_x_d  = 3'd0;
    rom_y_d  = 3'd0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (valid_q[i] && ((pix_x - x_q[i]) <= 10'd5) && ((pix_y - y_q[i]) <= 10'd5)) begin
        rom_en_d = 1'b1;
        rom_x_d  = 3'(pix_x - x_q[i]);
        rom_y_d  = 3'(pix_y - y_q[i]);
      end else begin
      end
    end
  end

  // Frame FSM: IDLE -> UPDATE (one slot per cycle) -> SPAWN -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_tick) begin
            state_q <= UPDATE;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
          cnt_q <= 3'd0;
        end
        UPDATE: begin
          if (cnt_q == 3'(NSLOT - 1)) begin
            state_q <= SPAWN;
            cnt_q   <= 3'd0;
          end else begin
            cnt_q   <= cnt_q + 3'd1;
          end
          busy_q <= 1'b1;
        end
        SPAWN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= 3'd0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

  // Slot, request and lookup registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      dir_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      pend_p_q <= 1'b0;
      pend_e_q <= 1'b0;
      prio_q   <= 1'b0;
      rom_en_q <= 1'b0;
      rom_x_q  <= 3'd0;
      rom_y_q  <= 3'd0;
    end else begin
      valid_q  <= valid_d;
      dir_q    <= dir_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pend_p_q <= pend_p_d;
      pend_e_q <= pend_e_d;
      prio_q   <= prio_d;
      rom_en_q <= rom_en_d;
      rom_x_q  <= rom_x_d;
      rom_y_q  <= rom_y_d;
    end
  end

  assign rom_en = rom_en_q;
  assign rom_x  = rom_x_q;
  assign rom_y  = rom_y_q;
  assign busy   = busy_q;
  assign active = valid_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Bench for bullet_ctrl: frame-level reference model compared every cycle, plus directed literal checks.
module tb_bullet_ctrl;
  localparam int NS = 4;
  localparam int SP = 4;
  localparam int SH = 480;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic fire_p = 1'b0;
  logic fire_e = 1'b0;
  logic [9:0] p_x = 10'd0, p_y = 10'd0, e_x = 10'd0, e_y = 10'd0;
  logic [9:0] pix_x = 10'd0, pix_y = 10'd0;
`ifdef BULLET_HIT_EN
  logic hit_vld = 1'b0;
  logic [2:0] hit_idx = 3'd0;
`endif
  logic [2:0] rom_x, rom_y;
  logic rom_en, busy;
  logic [NS-1:0] active;

  int total = 0;
  int bad = 0;

  bullet_ctrl #(.NSLOT(NS), .SPEED(SP), .SCR_H(SH)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .fire_p(fire_p), .p_x(p_x), .p_y(p_y),
    .fire_e(fire_e), .e_x(e_x), .e_y(e_y),
    .pix_x(pix_x), .pix_y(pix_y),
`ifdef BULLET_HIT_EN
    .hit_vld(hit_vld), .hit_idx(hit_idx),
`endif
    .rom_x(rom_x), .rom_y(rom_y), .rom_en(rom_en), .busy(busy), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slots as plain integers; phase 0 idle, 1..NS visit slot phase-1, NS+1 spawn.
  int mx[NS], my[NS];
  bit mv[NS], md[NS];
  bit mpp, mpe, mprio;
  int mph;
  bit men;
  int mrx, mry;

  always @(posedge clk or negedge rst_n) begin : model
    int px, py, k;
    bit gp, ge;
    int fr[$];
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) begin mv[i] = 0; md[i] = 0; mx[i] = 0; my[i] = 0; end
      mpp = 0; mpe = 0; mprio = 0; mph = 0; men = 0; mrx = 0; mry = 0;
    end else begin
      px = int'(pix_x); py = int'(pix_y);
      men = 0; mrx = 0; mry = 0;
      for (int i = 0; i < NS; i++) begin
        if (!men && mv[i] && px >= mx[i] && px <= mx[i] + 5 && py >= my[i] && py <= my[i] + 5) begin
          men = 1; mrx = px - mx[i]; mry = py - my[i];
        end
      end
      gp = 0; ge = 0;
      if (mph == 0) begin
        if (frame_tick) mph = 1;
      end else if (mph <= NS) begin
        k = mph - 1;
        if (mv[k]) begin
          if (!md[k]) begin
            if (my[k] - SP < 0) mv[k] = 0; else my[k] = my[k] - SP;
          end else begin
            if (my[k] + SP > SH - 6) mv[k] = 0; else my[k] = my[k] + SP;
          end
        end
        mph++;
      end else begin
        fr.delete();
        for (int i = 0; i < NS; i++) if (!mv[i]) fr.push_back(i);
        if (mpp && mpe && fr.size() >= 2) begin
          gp = 1; ge = 1;
        end else if (mpp && mpe && fr.size() == 1) begin
          if (mprio) ge = 1; else gp = 1;
          mprio = !mprio;
        end else if (fr.size() >= 1) begin
          gp = mpp; ge = mpe;
        end
        if (gp) begin
          k = fr.pop_front();
          mv[k] = 1; md[k] = 0; mx[k] = int'(p_x); my[k] = int'(p_y);
        end
        if (ge) begin
          k = fr.pop_front();
          mv[k] = 1; md[k] = 1; mx[k] = int'(e_x); my[k] = int'(e_y);
        end
        mph = 0;
      end
`ifdef BULLET_HIT_EN
      if (hit_vld && int'(hit_idx) < NS) mv[hit_idx] = 0;
`endif
      mpp = fire_p || (mpp && !gp);
      mpe = fire_e || (mpe && !ge);
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    int ma;
    ma = 0;
    for (int i = 0; i < NS; i++) if (mv[i]) ma = ma | (1 << i);
    chk("cmp_active", int'(active), ma);
    chk("cmp_busy", int'(busy), (mph != 0) ? 1 : 0);
    chk("cmp_rom_en", int'(rom_en), int'(men));
    chk("cmp_rom_x", int'(rom_x), mrx);
    chk("cmp_rom_y", int'(rom_y), mry);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fire(input bit p, input bit e);
    fire_p = p; fire_e = e;
    step(1);
    fire_p = 1'b0; fire_e = 1'b0;
  endtask

  task automatic frame();
    int n;
    n = 0;
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    while (busy && n < 20) begin step(1); n++; end
    chk("frame_done", int'(busy), 0);
  endtask

  task automatic look(input string name, input int x, input int y, input int en, input int rx, input int ry);
    pix_x = 10'(x); pix_y = 10'(y);
    step(1);
    chk({name, "_en"}, int'(rom_en), en);
    chk({name, "_x"}, int'(rom_x), rx);
    chk({name, "_y"}, int'(rom_y), ry);
  endtask

  task automatic rst();
    #2 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    p_x = 10'd100; p_y = 10'd200; e_x = 10'd300; e_y = 10'd100;
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("reset_active", int'(active), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rom_en", int'(rom_en), 0);

    // First spawn lands NSLOT+1 cycles after the tick edge.
    fire(1'b1, 1'b0);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    chk("tick_busy", int'(busy), 1);
    step(4);
    chk("spawn_busy", int'(busy), 1);
    chk("pre_spawn_active", int'(active), 0);
    step(1);
    chk("post_spawn_active", int'(active), 4'b0001);
    chk("post_spawn_busy", int'(busy), 0);
    look("pix_origin", 100, 200, 1, 0, 0);
    look("pix_3_5", 103, 205, 1, 3, 5);
    look("pix_x_out", 106, 205, 0, 0, 0);
    look("pix_y_above", 100, 199, 0, 0, 0);
    frame();
    look("moved_up", 100, 196, 1, 0, 0);
    look("moved_up_dy4", 100, 200, 1, 0, 4);

    // Up bullet near the top leaves instead of wrapping.
    rst();
    p_y = 10'd3;
    fire(1'b1, 1'b0);
    frame();
    chk("y3_active", int'(active), 4'b0001);
    frame();
    chk("y3_freed", int'(active), 0);
    look("no_wrap", 100, 1023, 0, 0, 0);

    // Down bullet: 470 -> 474 (exactly at limit), then freed.
    rst();
    e_x = 10'd50; e_y = 10'd470;
    fire(1'b0, 1'b1);
    frame();
    look("down_470", 50, 470, 1, 0, 0);
    frame();
    look("down_474", 50, 474, 1, 0, 0);
    frame();
    chk("down_freed", int'(active), 0);

    // Arbitration with a single free slot.
    rst();
    e_x = 10'd300; e_y = 10'd100; p_x = 10'd100; p_y = 10'd12;
    fire(1'b1, 1'b0); frame();
    p_y = 10'd200;
    fire(1'b1, 1'b0); frame();
    fire(1'b1, 1'b0); frame();
    chk("three_full", int'(active), 4'b0111);
    look("overlap_low_idx", 102, 201, 1, 2, 5);
    fire(1'b1, 1'b1); frame();
    chk("player_gets_slot3", int'(active), 4'b1111);
    look("enemy_pending", 300, 100, 0, 0, 0);
    fire(1'b1, 1'b0); frame();
    chk("enemy_granted_active", int'(active), 4'b1111);
    look("enemy_granted", 300, 100, 1, 0, 0);

    // Asynchronous reset in the second UPDATE cycle.
    fire(1'b0, 1'b1);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(1);
    chk("mid_update_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_active", int'(active), 0);
    chk("async_rom_en", int'(rom_en), 0);
    chk("async_rom_y", int'(rom_y), 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    frame();
    chk("pending_lost", int'(active), 0);

`ifdef BULLET_HIT_EN
    rst();
    p_x = 10'd100; p_y = 10'd200;
    fire(1'b1, 1'b0); frame();
    fire(1'b1, 1'b0); frame();
    chk("hit_setup", int'(active), 4'b0011);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(1);
    hit_vld = 1'b1; hit_idx = 3'd1;
    step(1);
    hit_vld = 1'b0;
    chk("hit_cleared", int'(active), 4'b0001);
    step(4);
    chk("hit_frame_done", int'(busy), 0);
`endif

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
